// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO over an inferred simple dual-port RAM with a registered read port.
// Tracks occupancy and provides full/empty/almost flags plus sticky overflow/underflow.
module sync_fifo_ram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  DEPTH      = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(32'd1);
  localparam logic [31:0]         AFULL_LVL  = 32'(AFULL_THRESH);
  localparam logic [31:0]         AEMPTY_LVL = 32'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  r_valid_q, r_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok_s, pop_ok_s, mem_we_s;
  logic                  full_s, empty_s;
  logic [31:0]           count_ext_s;

  // Status flags decoded from the registered occupancy.
  always_comb begin
    count_ext_s  = {{(31-ADDR_WIDTH){1'b0}}, count_q};
    full_s       = (count_q == DEPTH_CNT);
    empty_s      = (count_q == {(ADDR_WIDTH+1){1'b0}});
    almost_full  = (count_ext_s >= AFULL_LVL);
    almost_empty = (count_ext_s <= AEMPTY_LVL);
  end

  // Accept decisions, pointer/count next state and sticky error flags.
  always_comb begin
    pop_ok_s    = pop & ~empty_s;
    push_ok_s   = push & (~full_s | pop_ok_s);
    mem_we_s    = push_ok_s & ~reset;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    r_valid_d   = pop_ok_s;
    overflow_d  = overflow_q | (push & ~push_ok_s);
    underflow_d = underflow_q | (pop & ~pop_ok_s);

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous accepted push and pop leave occupancy unchanged.
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      count_q     <= {(ADDR_WIDTH+1){1'b0}};
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wr_ptr_q] <= w_data;
    end
  end

  // Registered read port; old contents are returned when a full FIFO overwrites the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_q <= {DATA_WIDTH{1'b0}};
    end else if (pop_ok_s) begin
      r_data_q <= mem[rd_ptr_q];
    end else begin
      r_data_q <= r_data_q;
    end
  end

  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
